evm_ballot_ctrl: RTL and testbench

Session controller for the electronic voting machine. It sequences the poll through open, armed, vote, lockout and closed phases, and arbitrates the four candidate buttons so at most one vote commits per officer arming. It drives one-cycle, one-hot vote pulses to the per-candidate 4-bit tally counters. After close, it scans the result multiplexer select across the four tallies.

---
 rtl/evm_ballot_ctrl.sv | 174 +++++++++++++++++
 tb/tb_evm_ballot_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/evm_ballot_ctrl.sv
// Ballot session controller for the voting machine: poll phase sequencing,
// one-vote-per-arming arbitration of candidate buttons and post-close result scan.
module evm_ballot_ctrl #(
  parameter int LOCKOUT_CYCLES = 8,
  parameter int RESULT_DWELL   = 16,
  parameter int CNT_W          = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             poll_open,
  input  logic             poll_close,
  input  logic             ballot_arm,
  input  logic [3:0]       vote_btn,
  output logic [3:0]       vote_pulse,
  output logic             ballot_ready,
  output logic             reject,
  output logic [CNT_W-1:0] total_votes,
  output logic             full,
  output logic [1:0]       result_sel,
  output logic             result_valid,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OPEN    = 3'd1,
    ST_ARMED   = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_CLOSED  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] TOTAL_MAX  = '1;
  localparam logic [7:0]       LOCK_LOAD  = 8'(LOCKOUT_CYCLES - 1);
  localparam logic [7:0]       DWELL_LAST = 8'(RESULT_DWELL - 1);

  state_t           state_q, state_d;
  logic             arm_q;
  logic [3:0]       btn_q;
  logic [7:0]       lock_cnt_q, lock_cnt_d;
  logic [7:0]       dwell_q, dwell_d;
  logic             close_latch_q, close_latch_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic             full_q, full_d;
  logic [3:0]       pulse_q, pulse_d;
  logic             ready_q, ready_d;
  logic             reject_q, reject_d;
  logic [1:0]       sel_q, sel_d;
  logic             valid_q, valid_d;

  logic             arm_rise;
  logic [3:0]       btn_rise;
  logic             btn_single;
  logic             btn_multi;

  // Edge registers run in every state, so a button held across arming never registers a rise.
  assign arm_rise   = ballot_arm & ~arm_q;
  assign btn_rise   = vote_btn & ~btn_q;
  assign btn_single = (btn_rise != 4'd0) && ((btn_rise & (btn_rise - 4'd1)) == 4'd0);
  assign btn_multi  = (btn_rise != 4'd0) && !btn_single;

  always_comb begin
    state_d       = state_q;
    lock_cnt_d    = lock_cnt_q;
    dwell_d       = dwell_q;
    close_latch_d = close_latch_q;
    total_d       = total_q;
    sel_d         = sel_q;
    pulse_d       = 4'd0;
    reject_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (poll_open) state_d = ST_OPEN;
      end
      ST_OPEN: begin
        if (poll_close) begin
          state_d = ST_CLOSED;
          sel_d   = 2'd0;
          dwell_d = 8'd0;
        end else if (arm_rise && !full_q) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        // Close cancels the open ballot outright, even against a simultaneous press.
        if (poll_close) begin
          state_d = ST_CLOSED;
          sel_d   = 2'd0;
          dwell_d = 8'd0;
        end else if (btn_single) begin
          pulse_d       = btn_rise;
          total_d       = (total_q == TOTAL_MAX) ? total_q : total_q + 1'b1;
          lock_cnt_d    = LOCK_LOAD;
          close_latch_d = 1'b0;
          state_d       = ST_LOCKOUT;
        end else if (btn_multi) begin
          reject_d = 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (lock_cnt_q == 8'd0) begin
          close_latch_d = 1'b0;
          if (close_latch_q || poll_close) begin
            state_d = ST_CLOSED;
            sel_d   = 2'd0;
            dwell_d = 8'd0;
          end else begin
            state_d = ST_OPEN;
          end
        end else begin
          lock_cnt_d    = lock_cnt_q - 8'd1;
          close_latch_d = close_latch_q | poll_close;
        end
      end
      ST_CLOSED: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = 8'd0;
          sel_d   = sel_q + 2'd1;
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_ARMED);
    valid_d = (state_d == ST_CLOSED);
    full_d  = (total_d == TOTAL_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      arm_q         <= 1'b0;
      btn_q         <= 4'd0;
      lock_cnt_q    <= 8'd0;
      dwell_q       <= 8'd0;
      close_latch_q <= 1'b0;
      total_q       <= '0;
      full_q        <= 1'b0;
      pulse_q       <= 4'd0;
      ready_q       <= 1'b0;
      reject_q      <= 1'b0;
      sel_q         <= 2'd0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      arm_q         <= ballot_arm;
      btn_q         <= vote_btn;
      lock_cnt_q    <= lock_cnt_d;
      dwell_q       <= dwell_d;
      close_latch_q <= close_latch_d;
      total_q       <= total_d;
      full_q        <= full_d;
      pulse_q       <= pulse_d;
      ready_q       <= ready_d;
      reject_q      <= reject_d;
      sel_q         <= sel_d;
      valid_q       <= valid_d;
    end
  end

  assign vote_pulse   = pulse_q;
  assign ballot_ready = ready_q;
  assign reject       = reject_q;
  assign total_votes  = total_q;
  assign full         = full_q;
  assign result_sel   = sel_q;
  assign result_valid = valid_q;
  assign state        = state_q;

endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// Bench for evm_ballot_ctrl: directed poll scenarios plus random traffic,
// checked every cycle against a timestamp-based reference of the session rules.
module tb_evm_ballot_ctrl;

  localparam int LOCK  = 8;
  localparam int DWELL = 16;
  localparam int CW    = 4;
  localparam int MAXV  = (1 << CW) - 1;

  localparam int M_IDLE    = 0;
  localparam int M_OPEN    = 1;
  localparam int M_ARMED   = 2;
  localparam int M_LOCKOUT = 3;
  localparam int M_CLOSED  = 4;

  logic          clk;
  logic          reset;
  logic          poll_open;
  logic          poll_close;
  logic          ballot_arm;
  logic [3:0]    vote_btn;
  logic [3:0]    vote_pulse;
  logic          ballot_ready;
  logic          reject;
  logic [CW-1:0] total_votes;
  logic          full;
  logic [1:0]    result_sel;
  logic          result_valid;
  logic [2:0]    state;

  int compare_count;
  int mismatch_count;

  // Reference model: phase, vote total and event timestamps
  int         m_state;
  int         m_total;
  int         edge_n;
  int         lock_end;
  int         close_edge;
  bit         m_close_seen;
  logic       m_prev_arm;
  logic [3:0] m_prev_btn;
  int         exp_pulse;
  int         exp_reject;

  evm_ballot_ctrl #(
    .LOCKOUT_CYCLES(LOCK),
    .RESULT_DWELL  (DWELL),
    .CNT_W         (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .poll_open   (poll_open),
    .poll_close  (poll_close),
    .ballot_arm  (ballot_arm),
    .vote_btn    (vote_btn),
    .vote_pulse  (vote_pulse),
    .ballot_ready(ballot_ready),
    .reject      (reject),
    .total_votes (total_votes),
    .full        (full),
    .result_sel  (result_sel),
    .result_valid(result_valid),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compare_count++;
    if (observed != expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s at edge %0d: got %0d expected %0d", tag, edge_n, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_state      = M_IDLE;
    m_total      = 0;
    lock_end     = 0;
    close_edge   = 0;
    m_close_seen = 1'b0;
    m_prev_arm   = 1'b0;
    m_prev_btn   = 4'd0;
    exp_pulse    = 0;
    exp_reject   = 0;
  endtask

  task automatic closeNow();
    m_state    = M_CLOSED;
    close_edge = edge_n;
  endtask

  task automatic modelStep();
    logic       arm_rise;
    logic [3:0] btn_rise;
    edge_n++;
    arm_rise   = ballot_arm & ~m_prev_arm;
    btn_rise   = vote_btn & ~m_prev_btn;
    m_prev_arm = ballot_arm;
    m_prev_btn = vote_btn;
    exp_pulse  = 0;
    exp_reject = 0;
    case (m_state)
      M_IDLE:  if (poll_open) m_state = M_OPEN;
      M_OPEN: begin
        if (poll_close) closeNow();
        else if (arm_rise && m_total < MAXV) m_state = M_ARMED;
      end
      M_ARMED: begin
        if (poll_close) closeNow();
        else if ($countones(btn_rise) == 1) begin
          exp_pulse    = int'(btn_rise);
          if (m_total < MAXV) m_total++;
          lock_end     = edge_n + LOCK;
          m_close_seen = 1'b0;
          m_state      = M_LOCKOUT;
        end else if ($countones(btn_rise) > 1) begin
          exp_reject = 1;
        end
      end
      M_LOCKOUT: begin
        if (poll_close) m_close_seen = 1'b1;
        if (edge_n == lock_end) begin
          if (m_close_seen) closeNow();
          else m_state = M_OPEN;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compareAll();
    int exp_sel;
    exp_sel = (m_state == M_CLOSED) ? (((edge_n - close_edge) / DWELL) % 4) : 0;
    checkOutput("state", int'(state), m_state);
    checkOutput("vote_pulse", int'(vote_pulse), exp_pulse);
    checkOutput("ballot_ready", int'(ballot_ready), int'(m_state == M_ARMED));
    checkOutput("reject", int'(reject), exp_reject);
    checkOutput("total_votes", int'(total_votes), m_total);
    checkOutput("full", int'(full), int'(m_total == MAXV));
    checkOutput("result_sel", int'(result_sel), exp_sel);
    checkOutput("result_valid", int'(result_valid), int'(m_state == M_CLOSED));
  endtask

  // Inputs change on the falling edge; the model and DUT both sample them on the rising edge
  task automatic tick();
    @(posedge clk);
    if (!reset) modelStep();
    @(negedge clk);
    compareAll();
  endtask

  task automatic applyStimulus(input logic o, input logic c, input logic a, input logic [3:0] b);
    poll_open  = o;
    poll_close = c;
    ballot_arm = a;
    vote_btn   = b;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    #1;
    modelReset();
    compareAll();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
    reset = 1'b0;
  endtask

  initial begin
    compare_count  = 0;
    mismatch_count = 0;
    edge_n         = 0;
    poll_open      = 1'b0;
    poll_close     = 1'b0;
    ballot_arm     = 1'b0;
    vote_btn       = 4'd0;
    reset          = 1'b1;
    #2;
    modelReset();
    compareAll();
    @(negedge clk);
    reset = 1'b0;

    // Single vote for C, then the full lockout back to OPEN
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0100);
    idle(10);

    // Double press rejected, then D commits
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0011);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1000);
    idle(10);

    // B held across arming does not vote until re-pressed
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0010);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0010);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 4'b0010);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0010);

    // Presses, an arm rise and a close pulse during lockout
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
    idle(40);
    doReset();

    // Fill the total to saturation, try one more arming, then close and scan
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
    for (int v = 0; v < MAXV; v++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 4'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'(1 << (v % 4)));
      idle(LOCK);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
    idle(5 * DWELL);
    doReset();

    // Reset asserted in the cycle the vote pulse is out
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001);
    doReset();

    // Random traffic with periodic resets so the closed phase is not absorbing
    for (int i = 0; i < 2000; i++) begin
      int         r;
      logic [3:0] b;
      if (i % 300 == 299) doReset();
      r = int'($urandom_range(0, 9));
      if (r < 5)      b = 4'd0;
      else if (r < 8) b = 4'(1 << $urandom_range(0, 3));
      else if (r < 9) b = 4'($urandom_range(0, 15));
      else            b = vote_btn;
      applyStimulus(($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 80) == 0),
                    ($urandom_range(0, 2) == 0) ? ~ballot_arm : ballot_arm,
                    b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
